// File: rtl/hilo_muldiv_unit.sv
// HI/LO register file with iterative multiply/divide for the EX stage.
// Optional HILO_FAST_MULT_EN: single-cycle combinational MULT/MULTU.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic [4:0]       alucontrol_i,
  input  logic [WIDTH-1:0] srca_i,
  input  logic [WIDTH-1:0] srcb_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hilo_rdata_o,
  output logic             stall_o
);

  localparam logic [4:0] OP_MULT  = 5'b11000;
  localparam logic [4:0] OP_MULTU = 5'b11001;
  localparam logic [4:0] OP_DIV   = 5'b11010;
  localparam logic [4:0] OP_DIVU  = 5'b11011;
  localparam logic [4:0] OP_MFHI  = 5'b11100;
  localparam logic [4:0] OP_MTHI  = 5'b11101;
  localparam logic [4:0] OP_MFLO  = 5'b11110;
  localparam logic [4:0] OP_MTLO  = 5'b11111;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   hi, lo, a_raw, divisor, a_mag;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               op_div, neg_q, neg_r, div_zero;
  logic               is_mul, is_div, is_sgn, go, start, fast, issue;

  assign is_mul = (alucontrol_i == OP_MULT) || (alucontrol_i == OP_MULTU);
  assign is_div = (alucontrol_i == OP_DIV) || (alucontrol_i == OP_DIVU);
  assign is_sgn = (alucontrol_i == OP_MULT) || (alucontrol_i == OP_DIV);
  assign go     = en_i & ~flush_i;
  assign start  = go & (is_mul | is_div) & (state == IDLE);

`ifdef HILO_FAST_MULT_EN
  logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
  assign ext_a = is_sgn ? {{WIDTH{srca_i[WIDTH-1]}}, srca_i}
                        : {{WIDTH{1'b0}}, srca_i};
  assign ext_b = is_sgn ? {{WIDTH{srcb_i[WIDTH-1]}}, srcb_i}
                        : {{WIDTH{1'b0}}, srcb_i};
  assign fast_prod = ext_a * ext_b;
  assign fast = start & is_mul;
`else
  assign fast = 1'b0;
`endif

  assign issue = start & ~fast;
  assign a_mag = (is_sgn & srca_i[WIDTH-1]) ? -srca_i : srca_i;

  // Magnitudes are iterated; signs are re-applied on the final cycle.
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next, step, prod;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, divisor} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]}
                   - {1'b0, divisor};
  assign div_next  = div_trial[WIDTH]
                   ? {acc[2*WIDTH-2:0], 1'b0}
                   : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign step = op_div ? div_next : mul_next;
  assign prod = neg_q ? -step : step;

  always_comb begin
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (op_div) begin
      if (div_zero) begin
        res_hi = a_raw;
        res_lo = '1;
      end else begin
        res_lo = neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
        res_hi = neg_r ? -step[2*WIDTH-1:WIDTH]
                       : step[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    unique case (state)
      IDLE: begin
        stall_o = issue;
        if (issue) state_nxt = BUSY;
      end
      BUSY: begin
        stall_o = 1'b1;
        if (flush_i) state_nxt = IDLE;
        else if (cnt == LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      acc      <= '0;
      a_raw    <= '0;
      divisor  <= '0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        cnt      <= '0;
        acc      <= {{WIDTH{1'b0}}, a_mag};
        a_raw    <= srca_i;
        divisor  <= (is_sgn & srcb_i[WIDTH-1]) ? -srcb_i : srcb_i;
        op_div   <= is_div;
        neg_q    <= is_sgn & (srca_i[WIDTH-1] ^ srcb_i[WIDTH-1]);
        neg_r    <= is_sgn & srca_i[WIDTH-1];
        div_zero <= (srcb_i == '0);
      end
`ifdef HILO_FAST_MULT_EN
      if (fast) begin
        hi <= fast_prod[2*WIDTH-1:WIDTH];
        lo <= fast_prod[WIDTH-1:0];
      end
`endif
      if (state == IDLE && go) begin
        if (alucontrol_i == OP_MTHI) hi <= srca_i;
        if (alucontrol_i == OP_MTLO) lo <= srca_i;
      end
      if (state == BUSY && !flush_i) begin
        acc <= step;
        cnt <= cnt + CW'(1);
        if (cnt == LAST) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end
    end
  end

  assign hi_o = hi;
  assign lo_o = lo;

  always_comb begin
    hilo_rdata_o = '0;
    unique case (1'b1)
      alucontrol_i == OP_MFHI: hilo_rdata_o = hi;
      alucontrol_i == OP_MFLO: hilo_rdata_o = lo;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: vector table, corner
// sequences and randomized ops against a plain-arithmetic model.
module tb_hilo_muldiv_unit;

  localparam int W = 32;
  localparam logic [4:0] OP_MULT  = 5'b11000;
  localparam logic [4:0] OP_MULTU = 5'b11001;
  localparam logic [4:0] OP_DIV   = 5'b11010;
  localparam logic [4:0] OP_DIVU  = 5'b11011;
  localparam logic [4:0] OP_MFHI  = 5'b11100;
  localparam logic [4:0] OP_MTHI  = 5'b11101;
  localparam logic [4:0] OP_MFLO  = 5'b11110;
  localparam logic [4:0] OP_MTLO  = 5'b11111;
  localparam logic [4:0] OP_ADD   = 5'b00010;
`ifdef HILO_FAST_MULT_EN
  localparam int MSTALL = 0;
`else
  localparam int MSTALL = W + 1;
`endif
  localparam int DSTALL = W + 1;

  logic         clk = 1'b0;
  logic         rst, en, flush;
  logic [4:0]   op;
  logic [W-1:0] srca, srcb, hi, lo, rdata;
  logic         stall;

  int checks = 0;
  int errors = 0;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en_i(en), .flush_i(flush),
    .alucontrol_i(op), .srca_i(srca), .srcb_i(srcb),
    .hi_o(hi), .lo_o(lo), .hilo_rdata_o(rdata), .stall_o(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not end, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  // counts HI/LO value changes while enabled
  logic        mon_en = 1'b0;
  logic [63:0] prev;
  int          writes = 0;
  always @(negedge clk) begin
    prev <= {hi, lo};
    if (mon_en && ({hi, lo} != prev)) writes <= writes + 1;
  end

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, hi, lo;
    int          stall;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic [4:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit hold,
                       output int n);
    en = 1'b1; op = o; srca = a; srcb = b;
    #1;
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(negedge clk); #1;
    end
    @(negedge clk); #1;
    if (!hold) en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] o, output logic [31:0] d);
    en = 1'b1; op = o;
    #1;
    d = rdata;
    @(negedge clk); #1;
    en = 1'b0;
  endtask

  function automatic logic [63:0] model(input logic [4:0] o,
      input logic [31:0] a, input logic [31:0] b,
      input logic [63:0] cur);
    longint sa, sb, q, rm;
    logic [63:0] r;
    r  = cur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULT:  r = sa * sb;
      OP_MULTU: r = {32'h0, a} * {32'h0, b};
      OP_DIV:
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          q  = sa / sb;
          rm = sa % sb;
          r  = {rm[31:0], q[31:0]};
        end
      OP_DIVU:
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      OP_MTHI: r[63:32] = a;
      OP_MTLO: r[31:0]  = a;
      default: ;
    endcase
    return r;
  endfunction

  function automatic int exp_stall(input logic [4:0] o);
    if (o == OP_MULT || o == OP_MULTU) return MSTALL;
    if (o == OP_DIV || o == OP_DIVU) return DSTALL;
    return 0;
  endfunction

  logic [4:0]  rops[6];
  logic [63:0] cur, exp;
  logic [31:0] d, a, b;
  int          n, k;

  initial begin
    vecs[0] = '{OP_DIV,   32'hFFFFFFF9, 32'h2,
                32'hFFFFFFFF, 32'hFFFFFFFD, DSTALL};
    vecs[1] = '{OP_DIVU,  32'h10, 32'h0,
                32'h10, 32'hFFFFFFFF, DSTALL};
    vecs[2] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFE, 32'h1, MSTALL};
    vecs[3] = '{OP_MULT,  32'hFFFFFFFE, 32'h3,
                32'hFFFFFFFF, 32'hFFFFFFFA, MSTALL};
    vecs[4] = '{OP_DIV,   32'h80000000, 32'h0,
                32'h80000000, 32'hFFFFFFFF, DSTALL};
    vecs[5] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF,
                32'h0, 32'h80000000, DSTALL};
    vecs[6] = '{OP_DIV,   32'h7, 32'hFFFFFFFE,
                32'h1, 32'hFFFFFFFD, DSTALL};
    vecs[7] = '{OP_DIVU,  32'hFFFFFFFF, 32'h1,
                32'h0, 32'hFFFFFFFF, DSTALL};
    vecs[8] = '{OP_MULT,  32'h80000000, 32'h80000000,
                32'h40000000, 32'h0, MSTALL};
    rops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};

    rst = 1'b1; en = 1'b0; flush = 1'b0;
    op = OP_MFHI; srca = '0; srcb = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_stall", stall, 0);
    check("reset_rdata", rdata, 0);
    rst = 1'b0;

    do_op(OP_MTHI, 32'h12345678, 0, 0, n);
    do_op(OP_MTLO, 32'h9ABCDEF0, 0, 0, n);
    check("mt_stall", n, 0);
    rd(OP_MFHI, d);
    check("mfhi", d, 32'h12345678);
    rd(OP_MFLO, d);
    check("mflo", d, 32'h9ABCDEF0);

    en = 1'b1; op = OP_ADD; srca = 32'h55; srcb = 32'h0;
    #1;
    check("ignored_stall", stall, 0);
    check("ignored_rdata", rdata, 0);
    @(negedge clk); #1;
    en = 1'b0;
    check("ignored_hilo", {hi, lo}, 64'h12345678_9ABCDEF0);

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, n);
      check($sformatf("vec%0d_stall", i), n, vecs[i].stall);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
    end

    // flush in BUSY aborts the divide
    do_op(OP_MTHI, 32'h11111111, 0, 0, n);
    do_op(OP_MTLO, 32'h22222222, 0, 0, n);
    en = 1'b1; op = OP_DIVU; srca = 32'd1000; srcb = 32'd7;
    #1;
    repeat (11) @(negedge clk);
    #1;
    check("flush_busy_stall", stall, 1);
    flush = 1'b1; en = 1'b0;
    @(negedge clk); #1;
    flush = 1'b0;
    check("flush_stall_next", stall, 0);
    repeat (40) @(negedge clk);
    #1;
    check("flush_hilo", {hi, lo}, 64'h11111111_22222222);
    check("flush_stall_later", stall, 0);

    en = 1'b1; op = OP_MTHI; srca = 32'hDEADBEEF; flush = 1'b1;
    @(negedge clk); #1;
    en = 1'b0; flush = 1'b0;
    check("flush_mthi", hi, 32'h11111111);

    // back-to-back MULTs with en held through the stall
    mon_en = 1'b1;
    do_op(OP_MULT, 32'd7, 32'd9, 1, n);
    check("b2b1_stall", n, MSTALL);
    check("b2b1_res", {hi, lo}, 64'd63);
    do_op(OP_MULT, 32'hFFFFFFFD, 32'd5, 0, n);
    check("b2b2_stall", n, MSTALL);
    check("b2b2_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    repeat (40) @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("b2b_writes", writes, 2);
    check("b2b_idle_stall", stall, 0);

    cur = {hi, lo};
    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(7);
      a = (k == 5) ? 32'($urandom_range(100)) : $urandom;
      k = $urandom_range(7);
      if (k == 0) b = 0;
      else if (k < 3) b = 32'($urandom_range(15));
      else if (k == 3) b = -32'($urandom_range(15));
      else b = $urandom;
      op = rops[$urandom_range(5)];
      exp = model(op, a, b, cur);
      do_op(op, a, b, 0, n);
      check($sformatf("rnd%0d_stall", i), n, exp_stall(op));
      check($sformatf("rnd%0d_hilo", i), {hi, lo}, exp);
      cur = exp;
    end
    rd(OP_MFHI, d);
    check("rnd_mfhi", d, cur[63:32]);

    // reset while BUSY clears HI/LO and no late write follows
    en = 1'b1; op = OP_DIVU; srca = 32'd100; srcb = 32'd7;
    #1;
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b1; en = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    check("rst_busy_hilo", {hi, lo}, 0);
    check("rst_busy_stall", stall, 0);
    repeat (40) @(negedge clk);
    #1;
    check("rst_busy_later", {hi, lo}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
